// File: rtl/ocp_slave_mem.sv
// Memory-backed OCP slave. It terminates single-request INCR bursts (WR, WRNP, RD) from one
// master against a local word array. Any other command or malformed burst gets one ERR beat.
module ocp_slave_mem #(
  parameter int unsigned TAGI_WIDTH = 5,
  parameter int unsigned INFO_WIDTH = 4,
  parameter int unsigned BLEN_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [BLEN_WIDTH-1:0]   m_burst_length,
  input  logic [2:0]              m_burst_seq,
  input  logic [DATA_WIDTH/8-1:0] m_byteen,
  input  logic [2:0]              m_cmd,
  input  logic [DATA_WIDTH-1:0]   m_data,
  input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
  input  logic                    m_data_last,
  input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
  input  logic                    m_data_valid,
  input  logic [INFO_WIDTH-1:0]   m_req_info,
  input  logic                    m_resp_accept,
  input  logic [TAGI_WIDTH-1:0]   m_tagid,
  output logic                    s_cmd_accept,
  output logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_data_accept,
  output logic [1:0]              s_resp,
  output logic                    s_resp_last,
  output logic [TAGI_WIDTH-1:0]   s_tagid
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  localparam logic [2:0] CmdIdle = 3'd0;
  localparam logic [2:0] CmdWr   = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdWrnp = 3'd5;
  localparam logic [2:0] SeqIncr = 3'b000;

  localparam logic [1:0] RespNull = 2'b00;
  localparam logic [1:0] RespDva  = 2'b01;
  localparam logic [1:0] RespErr  = 2'b11;

  localparam logic [BLEN_WIDTH-1:0] BlenOne = BLEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StWdata, StWresp, StRdresp, StErrresp} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BLEN_WIDTH-1:0]   len_q;
  logic [BLEN_WIDTH-1:0]   cnt_q;
  logic [TAGI_WIDTH-1:0]   tag_q;
  logic [NumBytes-1:0]     byteen_q;
  logic                    is_wrnp_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [Depth];

  logic                    cmd_err;
  logic                    tag_ok;
  logic                    beat_final;
  logic                    beat_err;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [BLEN_WIDTH-1:0]   cnt_nxt;
  logic                    unused_info;

  assign unused_info = ^m_req_info;

  // Zero the byte lanes whose enable is clear.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NumBytes-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Request decode and write-beat bookkeeping.
  always_comb begin
    cmd_err    = (m_burst_seq != SeqIncr) || (m_burst_length == '0) ||
                 !((m_cmd == CmdWr) || (m_cmd == CmdWrnp) || (m_cmd == CmdRd));
    addr_nxt   = addr_q + AddrOne;
    cnt_nxt    = cnt_q + BlenOne;
    tag_ok     = (m_data_tagid == tag_q);
    beat_final = (cnt_nxt == len_q);
    // Last flag must coincide exactly with beat number len; early last does not end the burst.
    beat_err   = !tag_ok || (m_data_last != beat_final);
    mem_we     = (state_q == StWdata) && m_data_valid && tag_ok;
  end

  // Byte-lane memory writes; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (m_data_byteen[i]) mem[addr_q][8*i +: 8] <= m_data[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      tag_q         <= '0;
      byteen_q      <= '0;
      is_wrnp_q     <= 1'b0;
      err_q         <= 1'b0;
      s_cmd_accept  <= 1'b0;
      s_data_accept <= 1'b0;
      s_data        <= '0;
      s_resp        <= RespNull;
      s_resp_last   <= 1'b0;
      s_tagid       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!s_cmd_accept) begin
            s_cmd_accept <= 1'b1;
          end else if (m_cmd != CmdIdle) begin
            s_cmd_accept <= 1'b0;
            addr_q       <= m_addr;
            len_q        <= m_burst_length;
            cnt_q        <= '0;
            tag_q        <= m_tagid;
            byteen_q     <= m_byteen;
            is_wrnp_q    <= (m_cmd == CmdWrnp);
            err_q        <= 1'b0;
            if (cmd_err) begin
              state_q     <= StErrresp;
              s_resp      <= RespErr;
              s_resp_last <= 1'b1;
              s_data      <= '0;
              s_tagid     <= m_tagid;
            end else if (m_cmd == CmdRd) begin
              // First read beat appears the cycle after acceptance.
              state_q     <= StRdresp;
              s_resp      <= RespDva;
              s_data      <= mem[m_addr] & lane_mask(m_byteen);
              s_resp_last <= (m_burst_length == BlenOne);
              s_tagid     <= m_tagid;
            end else begin
              state_q       <= StWdata;
              s_data_accept <= 1'b1;
            end
          end
        end
        StWdata: begin
          if (m_data_valid) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_nxt;
            err_q  <= err_q | beat_err;
            if (beat_final) begin
              s_data_accept <= 1'b0;
              if (is_wrnp_q) begin
                state_q     <= StWresp;
                s_resp      <= (err_q || beat_err) ? RespErr : RespDva;
                s_resp_last <= 1'b1;
                s_tagid     <= tag_q;
              end else begin
                state_q      <= StIdle;
                s_cmd_accept <= 1'b1;
              end
            end
          end
        end
        StRdresp: begin
          if (m_resp_accept) begin
            if (s_resp_last) begin
              state_q      <= StIdle;
              s_cmd_accept <= 1'b1;
              s_resp       <= RespNull;
              s_resp_last  <= 1'b0;
              s_data       <= '0;
              s_tagid      <= '0;
            end else begin
              addr_q      <= addr_nxt;
              cnt_q       <= cnt_nxt;
              s_data      <= mem[addr_nxt] & lane_mask(byteen_q);
              s_resp_last <= ((cnt_nxt + BlenOne) == len_q);
            end
          end
        end
        StWresp, StErrresp: begin
          if (m_resp_accept) begin
            state_q      <= StIdle;
            s_cmd_accept <= 1'b1;
            s_resp       <= RespNull;
            s_resp_last  <= 1'b0;
            s_data       <= '0;
            s_tagid      <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed and randomized bench for ocp_slave_mem against a word-array reference model.
module tb_ocp_slave_mem;

  localparam logic [2:0] CmdWr   = 3'd1;
  localparam logic [2:0] CmdRd   = 3'd2;
  localparam logic [2:0] CmdRdex = 3'd3;
  localparam logic [2:0] CmdWrnp = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [3:0]  m_burst_length = '0;
  logic [2:0]  m_burst_seq = '0;
  logic [3:0]  m_byteen = '0;
  logic [2:0]  m_cmd = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_data_byteen = '0;
  logic        m_data_last = 1'b0;
  logic [4:0]  m_data_tagid = '0;
  logic        m_data_valid = 1'b0;
  logic [3:0]  m_req_info = '0;
  logic        m_resp_accept = 1'b0;
  logic [4:0]  m_tagid = '0;
  logic        s_cmd_accept;
  logic [31:0] s_data;
  logic        s_data_accept;
  logic [1:0]  s_resp;
  logic        s_resp_last;
  logic [4:0]  s_tagid;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [32];
  logic [31:0] wdata [16];
  logic [3:0]  wbe [16];
  logic [4:0]  wtag [16];
  logic        wlast [16];

  ocp_slave_mem dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_addr         (m_addr),
    .m_burst_length (m_burst_length),
    .m_burst_seq    (m_burst_seq),
    .m_byteen       (m_byteen),
    .m_cmd          (m_cmd),
    .m_data         (m_data),
    .m_data_byteen  (m_data_byteen),
    .m_data_last    (m_data_last),
    .m_data_tagid   (m_data_tagid),
    .m_data_valid   (m_data_valid),
    .m_req_info     (m_req_info),
    .m_resp_accept  (m_resp_accept),
    .m_tagid        (m_tagid),
    .s_cmd_accept   (s_cmd_accept),
    .s_data         (s_data),
    .s_data_accept  (s_data_accept),
    .s_resp         (s_resp),
    .s_resp_last    (s_resp_last),
    .s_tagid        (s_tagid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask32(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] len,
                       input logic [2:0] seq, input logic [3:0] be, input logic [4:0] tag);
    int n;
    n = 0;
    while (s_cmd_accept !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept_ready", {31'b0, s_cmd_accept}, 32'd1);
    m_cmd = cmd; m_addr = addr; m_burst_length = len; m_burst_seq = seq;
    m_byteen = be; m_tagid = tag; m_req_info = 4'($urandom);
    @(negedge clk);
    m_cmd = 3'd0;
  endtask

  // Beats come from wdata/wbe/wtag/wlast; the model applies the write rules itself.
  task automatic do_write(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] len,
                          input logic [4:0] tag);
    bit err;
    int a;
    err = 1'b0;
    issue(cmd, addr, len, 3'b000, 4'hF, tag);
    for (int b = 0; b < int'(len); b++) begin
      check("data_accept_hi", {31'b0, s_data_accept}, 32'd1);
      m_data_valid = 1'b1; m_data = wdata[b]; m_data_byteen = wbe[b];
      m_data_tagid = wtag[b]; m_data_last = wlast[b];
      a = (int'(addr) + b) % 32;
      if (wtag[b] == tag)
        model_mem[a] = (model_mem[a] & ~mask32(wbe[b])) | (wdata[b] & mask32(wbe[b]));
      else
        err = 1'b1;
      if (wlast[b] != (b == int'(len) - 1)) err = 1'b1;
      @(negedge clk);
    end
    m_data_valid = 1'b0; m_data_last = 1'b0;
    check("data_accept_lo", {31'b0, s_data_accept}, 32'd0);
    if (cmd == CmdWrnp) begin
      check("wresp_code", {30'b0, s_resp}, err ? 32'd3 : 32'd1);
      check("wresp_last", {31'b0, s_resp_last}, 32'd1);
      check("wresp_tag", {27'b0, s_tagid}, {27'b0, tag});
      m_resp_accept = 1'b1;
      @(negedge clk);
      m_resp_accept = 1'b0;
    end
    check("no_resp_after_wr", {30'b0, s_resp}, 32'd0);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [3:0] len, input logic [3:0] be,
                         input logic [4:0] tag, input int hold_beat, input int hold_n);
    logic [31:0] exp;
    issue(CmdRd, addr, len, 3'b000, be, tag);
    for (int b = 0; b < int'(len); b++) begin
      exp = model_mem[(int'(addr) + b) % 32] & mask32(be);
      check("rd_resp", {30'b0, s_resp}, 32'd1);
      check("rd_data", s_data, exp);
      check("rd_last", {31'b0, s_resp_last}, (b == int'(len) - 1) ? 32'd1 : 32'd0);
      check("rd_tag", {27'b0, s_tagid}, {27'b0, tag});
      if (b == hold_beat) begin
        for (int h = 0; h < hold_n; h++) begin
          @(negedge clk);
          check("rd_hold_data", s_data, exp);
          check("rd_hold_resp", {30'b0, s_resp}, 32'd1);
        end
      end
      m_resp_accept = 1'b1;
      @(negedge clk);
      m_resp_accept = 1'b0;
    end
    check("rd_end_resp", {30'b0, s_resp}, 32'd0);
    check("rd_end_last", {31'b0, s_resp_last}, 32'd0);
  endtask

  task automatic do_err(input logic [2:0] cmd, input logic [3:0] len, input logic [2:0] seq,
                        input logic [4:0] tag);
    issue(cmd, 5'd4, len, seq, 4'hF, tag);
    check("err_resp", {30'b0, s_resp}, 32'd3);
    check("err_data", s_data, 32'd0);
    check("err_last", {31'b0, s_resp_last}, 32'd1);
    check("err_tag", {27'b0, s_tagid}, {27'b0, tag});
    m_resp_accept = 1'b1;
    @(negedge clk);
    m_resp_accept = 1'b0;
    check("err_end_resp", {30'b0, s_resp}, 32'd0);
  endtask

  task automatic fill_beats(input int len, input logic [4:0] tag);
    for (int b = 0; b < 16; b++) begin
      wdata[b] = $urandom; wbe[b] = 4'hF; wtag[b] = tag; wlast[b] = (b == len - 1);
    end
  endtask

  initial begin
    logic [4:0] ra;
    logic [3:0] rl;
    logic [4:0] rt;
    int kind;

    // Reset state.
    #1;
    check("rst_cmd_accept", {31'b0, s_cmd_accept}, 32'd0);
    check("rst_resp", {30'b0, s_resp}, 32'd0);
    check("rst_data_accept", {31'b0, s_data_accept}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_accept_lo", {31'b0, s_cmd_accept}, 32'd0);
    @(negedge clk);
    check("post_rst_accept_hi", {31'b0, s_cmd_accept}, 32'd1);

    // Give every word a known value.
    for (int blk = 0; blk < 4; blk++) begin
      fill_beats(8, 5'd1);
      do_write(CmdWr, 5'(blk * 8), 4'd8, 5'd1);
    end

    // Posted write then read back.
    fill_beats(2, 5'd7);
    wdata[0] = 32'hA5A5A5A5; wdata[1] = 32'h12345678;
    do_write(CmdWr, 5'd3, 4'd2, 5'd7);
    do_read(5'd3, 4'd2, 4'hF, 5'd9, -1, 0);
    check("tp1_word3", model_mem[3], 32'hA5A5A5A5);

    // Partial non-posted write over zero.
    fill_beats(1, 5'd2);
    wdata[0] = 32'h0;
    do_write(CmdWr, 5'd0, 4'd1, 5'd2);
    fill_beats(1, 5'd2);
    wdata[0] = 32'hFFFFFFFF; wbe[0] = 4'h3;
    do_write(CmdWrnp, 5'd0, 4'd1, 5'd2);
    check("tp2_model", model_mem[0], 32'h0000FFFF);
    do_read(5'd0, 4'd1, 4'hF, 5'd3, -1, 0);

    // Wrapping read with a stalled second beat.
    do_read(5'd31, 4'd3, 4'hF, 5'd5, 1, 4);

    // Error commands.
    do_err(CmdRdex, 4'd1, 3'b000, 5'd11);
    do_err(CmdRd, 4'd1, 3'b001, 5'd12);
    do_err(CmdRd, 4'd0, 3'b000, 5'd13);
    do_read(5'd2, 4'd4, 4'hF, 5'd14, -1, 0);

    // Early last on beat 1, tag mismatch on beat 2.
    fill_beats(2, 5'd4);
    wlast[0] = 1'b1; wtag[1] = 5'd5;
    do_write(CmdWrnp, 5'd10, 4'd2, 5'd4);
    do_read(5'd10, 4'd2, 4'hF, 5'd6, -1, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      ra = 5'($urandom);
      rl = 4'($urandom_range(1, 6));
      rt = 5'($urandom);
      if (kind == 2) begin
        do_read(ra, rl, 4'($urandom), rt, -1, 0);
      end else begin
        fill_beats(int'(rl), rt);
        for (int b = 0; b < int'(rl); b++) begin
          wbe[b] = 4'($urandom);
          if ($urandom_range(0, 7) == 0) wtag[b] = rt ^ 5'd1;
          if ($urandom_range(0, 7) == 0) wlast[b] = ~wlast[b];
        end
        do_write((kind == 0) ? CmdWr : CmdWrnp, ra, rl, rt);
      end
    end

    // Reset in the middle of a read burst.
    issue(CmdRd, 5'd31, 4'd3, 3'b000, 4'hF, 5'd8);
    check("mid_rd_beat1", s_data, model_mem[31]);
    m_resp_accept = 1'b1;
    @(negedge clk);
    m_resp_accept = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_resp", {30'b0, s_resp}, 32'd0);
    check("async_rst_data", s_data, 32'd0);
    check("async_rst_last", {31'b0, s_resp_last}, 32'd0);
    check("async_rst_tag", {27'b0, s_tagid}, 32'd0);
    check("async_rst_accept", {31'b0, s_cmd_accept}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_accept_lo", {31'b0, s_cmd_accept}, 32'd0);
    @(negedge clk);
    check("rel_accept_hi", {31'b0, s_cmd_accept}, 32'd1);
    do_read(5'd31, 4'd3, 4'hF, 5'd8, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocp_slave_mem.md
Name: ocp_slave_mem

Overview:
- Memory-backed OCP slave that connects to the slave modport of ocp_if and terminates transactions from one OCP master.
- Accepts single-request INCR bursts: WR (posted), WRNP (non-posted) and RD.
- Every other command, and every malformed burst, gets a single ERR response.
- Used as the default target for OCP master blocks and as the reference responder in block-level benches.

Parameters:
- TAGI_WIDTH, 5, width of m_tagid / m_data_tagid / s_tagid
- INFO_WIDTH, 4, width of m_req_info (accepted, ignored)
- BLEN_WIDTH, 4, width of m_burst_length; burst length in beats
- DATA_WIDTH, 32, data width; must be a multiple of 8
- ADDR_WIDTH, 5, word address width; memory depth is 2**ADDR_WIDTH words

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_addr  in  ADDR_WIDTH  burst start word address
- m_burst_length  in  BLEN_WIDTH  beats in burst
- m_burst_seq  in  3  burst sequence; only INCR=3'b000 supported
- m_byteen  in  DATA_WIDTH/8  read byte enables
- m_cmd  in  3  command, ocp_pkg encoding (IDLE=0, WR=1, RD=2, WRNP=5, ...)
- m_data  in  DATA_WIDTH  write data
- m_data_byteen  in  DATA_WIDTH/8  write data byte enables
- m_data_last  in  1  last write beat
- m_data_tagid  in  TAGI_WIDTH  write data tag
- m_data_valid  in  1  write data valid
- m_req_info  in  INFO_WIDTH  ignored
- m_resp_accept  in  1  master accepts current response
- m_tagid  in  TAGI_WIDTH  request tag
- s_cmd_accept  out  1  command accepted
- s_data  out  DATA_WIDTH  read data
- s_data_accept  out  1  write beat accepted
- s_resp  out  2  NULL=00, DVA=01, ERR=11
- s_resp_last  out  1  last response beat
- s_tagid  out  TAGI_WIDTH  response tag (= latched m_tagid)

Behaviour:
- Reset values: all outputs registered and reset to 0. Memory array is not reset. State resets to IDLE; s_cmd_accept rises on the first clock after rst_n is released.
- States are IDLE, WDATA, WRESP, RDRESP, ERRRESP.
- IDLE, s_cmd_accept=1:
  - A command is taken on the edge where m_cmd!=IDLE and s_cmd_accept=1. Addr, length, tag and byteen are latched; s_cmd_accept=0 from the next cycle.
  - Error condition: m_burst_seq!=INCR, or length==0, or m_cmd not in {WR, WRNP, RD}. The command is still accepted and the next state is ERRRESP.
  - WR or WRNP with no error -> WDATA.
  - RD with no error -> RDRESP.
- WDATA, s_data_accept=1:
  - Each edge with m_data_valid=1 consumes one beat. Byte lane i of mem[addr] is written when m_data_byteen[i]=1. addr increments mod 2**ADDR_WIDTH and the beat counter increments.
  - A beat whose m_data_tagid != latched tag is consumed without a write and sets the err flag.
  - m_data_last must be 1 exactly on beat number length. A mismatch sets err. The burst always ends on beat number length; a beat with an early last does not end it.
  - After the final beat: WR -> IDLE, no response (posted); WRNP -> WRESP.
- WRESP: drives s_resp=DVA, or ERR if err is set, with s_resp_last=1 and s_tagid=tag. Holds until m_resp_accept=1, then -> IDLE.
- RDRESP:
  - The first beat is presented the cycle after command acceptance.
  - Each beat: s_resp=DVA, s_data=mem[addr] with lanes where latched m_byteen=0 forced to 0, s_tagid=tag, s_resp_last=1 on beat number length.
  - All response outputs stay stable until m_resp_accept=1. addr then increments mod depth, wrapping 2**ADDR_WIDTH-1 -> 0.
  - After the last beat is accepted -> IDLE.
- ERRRESP: one beat with s_resp=ERR, s_data=0, s_resp_last=1, held until m_resp_accept=1, then -> IDLE. No memory access occurs.
- s_resp=NULL and s_resp_last=0 whenever no response is presented.
- Only one transaction is outstanding at a time; a new command is taken only in IDLE.
- Response accept to next s_cmd_accept=1 takes 1 cycle.
- Asynchronous reset mid-burst aborts immediately; partial writes already done remain in memory.

Test Plan:
- WR addr=3, len=2, data 0xA5A5A5A5/0x12345678, byteen 0xF, tag 7 -> no response; then RD addr=3, len=2, tag 9 -> beats 0xA5A5A5A5 and 0x12345678 with s_resp=01, s_tagid=9, s_resp_last only on beat 2.
- WRNP addr=0, len=1, data 0xFFFFFFFF, byteen 0x3 over an existing 0 -> one DVA with last=1; RD with m_byteen=0xF returns 0x0000FFFF.
- RD addr=31, len=3 -> reads mem[31], mem[0], mem[1] in order (wrap). m_resp_accept is held low 4 cycles on beat 2 -> s_data and s_resp are stable throughout.
- m_cmd=RDEX (3), m_cmd=RD with seq=3'b001, and RD with len=0 -> each gets exactly one ERR beat with s_data=0, last=1; memory unchanged.
- WRNP len=2 with beat-2 tag mismatch and m_data_last=1 on beat 1 -> both beats consumed, beat 1 written, single ERR response.
- rst_n pulsed low mid RD burst -> all outputs are 0 asynchronously; s_cmd_accept=1 one clock after release; a following RD of the same address returns the previously written data.
